// File: rtl/qcomp_pkg.sv
// Shared constants and op encoding for the Q-format negate/abs scheduler.
package qcomp_pkg;

    localparam int N_DEF    = 16;
    localparam int Q_DEF    = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic {
        OP_NEG = 1'b0,
        OP_ABS = 1'b1
    } op_e;

    // Extremes of the default word width.
    localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
    localparam logic [N_DEF-1:0] MIN_NEG = {1'b1, {(N_DEF-1){1'b0}}};

endpackage

// File: rtl/qcomp_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first set request at or above ptr, wrapping.
module qcomp_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qcomp_sched.sv
// Shared two-stage NEG/ABS unit with round-robin intake and saturating results.
module qcomp_sched
    import qcomp_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int Q    = Q_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_data,
    input  logic [NREQ-1:0]         req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_ovf
);

    localparam int PW = $clog2(NREQ);
    localparam logic [N-1:0] MAX_P = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

    // Q only labels the binary point; the arithmetic never looks at it.
    if (Q >= N) begin : g_q_range
        $error("qcomp_sched: Q must be smaller than N");
    end

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [PW-1:0]   gid;
    logic [PW-1:0]   ptr_next;
    logic [N-1:0]    gdata;
    logic            gop;

    logic            s1_valid;
    logic [N-1:0]    s1_data;
    op_e             s1_op;
    logic [PW-1:0]   s1_id;

    logic            s2_valid;
    logic [N-1:0]    s2_data;
    logic [PW-1:0]   s2_id;
    logic            s2_ovf;

    logic            s2_load;
    logic            s1_adv;
    logic [N-1:0]    res;
    logic            ovf;

    assign s2_load = !s2_valid || rsp_ready;
    assign s1_adv  = !s1_valid || s2_load;

    qcomp_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (s1_adv && !rst),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        gid   = '0;
        gdata = '0;
        gop   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gid   = PW'(i);
                gdata = req_data[i*N +: N];
                gop   = req_op[i];
            end
        end
        ptr_next = (gid == PW'(NREQ-1)) ? '0 : gid + 1'b1;
    end

    // The most-negative value has no positive twin, so it saturates for both ops.
    always_comb begin
        res = ~s1_data + 1'b1;
        ovf = 1'b0;
        if (s1_data == MIN_N) begin
            res = MAX_P;
            ovf = 1'b1;
        end else if (s1_op == OP_ABS && !s1_data[N-1]) begin
            res = s1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= OP_NEG;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            s2_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= ptr_next;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= res;
                    s2_id   <= s1_id;
                    s2_ovf  <= ovf;
                end
            end
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= gdata;
                    s1_op   <= op_e'(gop);
                    s1_id   <= gid;
                end
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;
    assign rsp_ovf   = s2_ovf;

endmodule

// File: tb/tb_qcomp_sched.sv
// Directed self-checking bench for qcomp_sched with default parameters.
module tb_qcomp_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;

    int passed = 0;
    int total  = 0;

    qcomp_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'h0; req_op = 4'h0; req_data = '0;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data got %h want 0000", rsp_data); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else passed++;
        total++; if (rsp_ovf !== 1'b0) $display("FAIL reset_rsp_ovf got %b want 0", rsp_ovf); else passed++;
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready got %b want 0000", req_ready); else passed++;
        req_valid = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_data[15:0] = 16'h0100; req_op[0] = 1'b0; req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else passed++;
        tick();
        req_valid = 4'h0;
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_early got %b want 0", rsp_valid); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got %b want 1", rsp_valid); else passed++;
        total++; if (rsp_data !== 16'hFF00) $display("FAIL single_data got %h want ff00", rsp_data); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL single_id got %0d want 0", rsp_id); else passed++;
        total++; if (rsp_ovf !== 1'b0) $display("FAIL single_ovf got %b want 0", rsp_ovf); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_drained got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_values();
        int          r   [6] = '{1, 2, 3, 0, 1, 2};
        logic        op  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] x   [6] = '{16'h8000, 16'hFE80, 16'h0040, 16'h0000, 16'h8000, 16'h7FFF};
        logic [15:0] exp [6] = '{16'h7FFF, 16'h0180, 16'h0040, 16'h0000, 16'h7FFF, 16'h8001};
        logic        eov [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 6; t++) begin
            req_data[r[t]*16 +: 16] = x[t];
            req_op[r[t]]            = op[t];
            req_valid               = 4'b0001 << r[t];
            #1;
            total++; if (req_ready !== (4'b0001 << r[t])) $display("FAIL values_ready[%0d] got %b want %b", t, req_ready, 4'b0001 << r[t]); else passed++;
            tick();
            req_valid = 4'h0;
            tick();
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp[t] || rsp_id !== 2'(r[t]) || rsp_ovf !== eov[t])
                $display("FAIL values[%0d] got v=%b d=%h id=%0d ovf=%b want v=1 d=%h id=%0d ovf=%b",
                         t, rsp_valid, rsp_data, rsp_id, rsp_ovf, exp[t], r[t], eov[t]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4] = '{16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        req_op   = 4'b0000;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 4) ? 4'hF : 4'h0;
            #1;
            if (c < 4) begin
                total++; if (req_ready !== (4'b0001 << c)) $display("FAIL b2b_grant[%0d] got %b want %b", c, req_ready, 4'b0001 << c); else passed++;
            end
            if (c >= 2) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(c-2) || rsp_data !== exp[c-2])
                    $display("FAIL b2b_rsp[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, c-2, exp[c-2]);
                else passed++;
            end
            tick();
        end
        req_valid = 4'h0;
    endtask

    task automatic test_stall();
        logic [3:0]  exp_rdy [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic        exp_v   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int          exp_id  [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
        logic [15:0] res     [4] = '{16'h7FFF, 16'h0180, 16'hFFC0, 16'h0003};
        logic        rov     [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        req_data = {16'h0003, 16'h0040, 16'hFE80, 16'h8000};
        req_op   = 4'b1010;
        for (int c = 0; c < 9; c++) begin
            rsp_ready = (c >= 4);
            req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            total++; if (req_ready !== exp_rdy[c]) $display("FAIL stall_ready[%0d] got %b want %b", c, req_ready, exp_rdy[c]); else passed++;
            total++;
            if (rsp_valid !== exp_v[c])
                $display("FAIL stall_valid[%0d] got %b want %b", c, rsp_valid, exp_v[c]);
            else if (exp_v[c] && (rsp_id !== 2'(exp_id[c]) || rsp_data !== res[exp_id[c]] || rsp_ovf !== rov[exp_id[c]]))
                $display("FAIL stall_rsp[%0d] got id=%0d d=%h ovf=%b want id=%0d d=%h ovf=%b",
                         c, rsp_id, rsp_data, rsp_ovf, exp_id[c], res[exp_id[c]], rov[exp_id[c]]);
            else passed++;
            tick();
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) $display("FAIL mid_inflight got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); else passed++;
        rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 16'h0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) $display("FAIL mid_outs got d=%h id=%0d ovf=%b want 0", rsp_data, rsp_id, rsp_ovf); else passed++;
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got %b want 0001", req_ready); else passed++;
        tick();
        req_valid = 4'h0; rsp_ready = 1'b1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale1 got %b want 0", rsp_valid); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h7FFF || rsp_ovf !== 1'b1)
            $display("FAIL mid_new got v=%b id=%0d d=%h ovf=%b want v=1 id=0 d=7fff ovf=1", rsp_valid, rsp_id, rsp_data, rsp_ovf);
        else passed++;
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale2 got %b want 0", rsp_valid); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_values();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
